// File: rtl/systolic_setup.sv
// Input data-setup stage for the systolic MAC array: accepts one activation vector per cycle
// and skews row i by i cycles so the wavefront enters the array diagonally aligned.
module systolic_setup #(
    parameter int unsigned ROW_NUMBER = 256
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [0:ROW_NUMBER-1][7:0]    in_data,
    output logic [0:ROW_NUMBER-1][7:0]    left_out,
    output logic [0:ROW_NUMBER-1]         left_valid,
    output logic                          busy,
    output logic                          done
);

    localparam int unsigned CntW = (ROW_NUMBER > 1) ? $clog2(ROW_NUMBER) : 1;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e          state_q;
    logic [CntW-1:0] cnt_q;
    logic            done_q;
    logic            accept;

    assign in_ready = !reset && (state_q != StDrain);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != StIdle);
    assign done     = done_q;

    // cnt_q counts the remaining drain cycles; done is registered one cycle ahead of the
    // final drain cycle so it lines up with the last element leaving the bottom row.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StRun: begin
                    if (accept) begin
                        if (in_last) begin
                            state_q <= StDrain;
                            cnt_q   <= CntW'(ROW_NUMBER - 1);
                            done_q  <= (ROW_NUMBER == 1);
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StDrain: begin
                    if (cnt_q == '0) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q  <= cnt_q - CntW'(1);
                        done_q <= (cnt_q == CntW'(1));
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Row i is a free-running chain of i+1 stages; bubbles inject zero data with valid low.
    for (genvar i = 0; i < ROW_NUMBER; i++) begin : g_row
        logic [7:0] data_q  [0:i];
        logic       valid_q [0:i];

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int s = 0; s <= i; s++) begin
                    data_q[s]  <= '0;
                    valid_q[s] <= 1'b0;
                end
            end else begin
                data_q[0]  <= accept ? in_data[i] : 8'd0;
                valid_q[0] <= accept;
                for (int s = 1; s <= i; s++) begin
                    data_q[s]  <= data_q[s-1];
                    valid_q[s] <= valid_q[s-1];
                end
            end
        end

        assign left_out[i]   = data_q[i];
        assign left_valid[i] = valid_q[i];
    end

endmodule

// File: tb/tb_systolic_setup.sv
// Bench for systolic_setup (4 rows): directed vector tables plus randomized traffic checked
// against a cycle-history reference model.
module tb_systolic_setup;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 reset, in_valid, in_ready, in_last, busy, done;
    logic [0:N-1][7:0]    in_data, left_out;
    logic [0:N-1]         left_valid;

    always #5 clk = ~clk;

    systolic_setup #(.ROW_NUMBER(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_last    (in_last),
        .in_data    (in_data),
        .left_out   (left_out),
        .left_valid (left_valid),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic        r, v, l;
        logic [31:0] d;
        logic [31:0] eo;
        logic [3:0]  ev;
        logic        ed, er;
    } vec_t;

    int          total = 0, bad = 0, cyc = 0;
    bit          rst_seen = 0, in_sess = 0;
    int          tlast = -1, rst_cyc = -1;
    bit          hv [0:4095];
    logic [31:0] hd [0:4095];
    vec_t        tab [$];

    function automatic vec_t mk(input logic r, v, l, input logic [31:0] d, eo,
                                input logic [3:0] ev, input logic ed, er);
        vec_t t;
        t.r = r; t.v = v; t.l = l; t.d = d; t.eo = eo; t.ev = ev; t.ed = ed; t.er = er;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] got, want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
        end
    endtask

    // Apply one cycle of inputs, compare against the model (and optional table row), advance.
    task automatic tick(input vec_t tv, input bit use_tab);
        logic [31:0] eo;
        logic [3:0]  ev;
        bit          drain, ready_e, acc;
        int          k;
        reset    = tv.r;
        in_valid = tv.v;
        in_last  = tv.l;
        in_data  = tv.d;
        @(negedge clk);
        drain   = in_sess && tlast >= 0 && cyc > tlast;
        ready_e = !tv.r && !drain;
        if (rst_seen) begin
            eo = '0;
            ev = '0;
            for (int i = 0; i < N; i++) begin
                k = cyc - 1 - i;
                if (k > rst_cyc && k >= 0 && hv[k]) begin
                    eo[31-8*i -: 8] = hd[k][31-8*i -: 8];
                    ev[N-1-i]       = 1'b1;
                end
            end
            check("left_out", left_out, eo);
            check("left_valid", 32'(left_valid), 32'(ev));
            check("busy", 32'(busy), 32'(in_sess));
            check("done", 32'(done), 32'(in_sess && tlast >= 0 && cyc == tlast + N));
            check("in_ready", 32'(in_ready), 32'(ready_e));
        end
        if (use_tab) begin
            check("tab_left_out", left_out, tv.eo);
            check("tab_left_valid", 32'(left_valid), 32'(tv.ev));
            check("tab_done", 32'(done), 32'(tv.ed));
            check("tab_in_ready", 32'(in_ready), 32'(tv.er));
        end
        acc = tv.v && ready_e;
        if (tv.r) begin
            in_sess  = 0;
            tlast    = -1;
            rst_cyc  = cyc;
            hv[cyc]  = 0;
            rst_seen = 1;
        end else begin
            hv[cyc] = acc;
            hd[cyc] = tv.d;
            if (in_sess && tlast >= 0 && cyc == tlast + N) begin
                in_sess = 0;
                tlast   = -1;
            end
            if (acc) begin
                in_sess = 1;
                if (tv.l) tlast = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    localparam logic [31:0] Z = 32'h0;

    initial begin
        vec_t t;
        for (int i = 0; i < 4096; i++) begin
            hv[i] = 0;
            hd[i] = '0;
        end
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        #1;

        tick(mk(1, 0, 0, Z, Z, 4'b0, 0, 0), 0);
        tick(mk(1, 0, 0, Z, Z, 4'b0, 0, 0), 1);
        tick(mk(0, 0, 0, Z, Z, 4'b0, 0, 1), 1);
        tick(mk(0, 0, 0, 32'hdeadbeef, Z, 4'b0, 0, 1), 1);

        // Single last vector
        tab.push_back(mk(0, 1, 1, 32'h01020304, Z,            4'b0000, 0, 1));
        tab.push_back(mk(0, 0, 0, Z,            32'h01000000, 4'b1000, 0, 0));
        tab.push_back(mk(0, 0, 0, Z,            32'h00020000, 4'b0100, 0, 0));
        tab.push_back(mk(0, 0, 0, Z,            32'h00000300, 4'b0010, 0, 0));
        tab.push_back(mk(0, 0, 0, Z,            32'h00000004, 4'b0001, 1, 0));
        tab.push_back(mk(0, 0, 0, Z,            Z,            4'b0000, 0, 1));
        // Back-to-back A, B, C(last)
        tab.push_back(mk(0, 1, 0, 32'h01010101, Z,            4'b0000, 0, 1));
        tab.push_back(mk(0, 1, 0, 32'h02020202, 32'h01000000, 4'b1000, 0, 1));
        tab.push_back(mk(0, 1, 1, 32'h03030303, 32'h02010000, 4'b1100, 0, 1));
        tab.push_back(mk(0, 0, 0, Z,            32'h03020100, 4'b1110, 0, 0));
        tab.push_back(mk(0, 0, 0, Z,            32'h00030201, 4'b0111, 0, 0));
        tab.push_back(mk(0, 0, 0, Z,            32'h00000302, 4'b0011, 0, 0));
        tab.push_back(mk(0, 0, 0, Z,            32'h00000003, 4'b0001, 1, 0));
        tab.push_back(mk(0, 0, 0, Z,            Z,            4'b0000, 0, 1));
        // A, bubble (garbage data), B(last)
        tab.push_back(mk(0, 1, 0, 32'h01010101, Z,            4'b0000, 0, 1));
        tab.push_back(mk(0, 0, 1, 32'h55555555, 32'h01000000, 4'b1000, 0, 1));
        tab.push_back(mk(0, 1, 1, 32'h02020202, 32'h00010000, 4'b0100, 0, 1));
        tab.push_back(mk(0, 0, 0, Z,            32'h02000100, 4'b1010, 0, 0));
        tab.push_back(mk(0, 0, 0, Z,            32'h00020001, 4'b0101, 0, 0));
        tab.push_back(mk(0, 0, 0, Z,            32'h00000200, 4'b0010, 0, 0));
        tab.push_back(mk(0, 0, 0, Z,            32'h00000002, 4'b0001, 1, 0));
        tab.push_back(mk(0, 0, 0, Z,            Z,            4'b0000, 0, 1));
        foreach (tab[i]) tick(tab[i], 1);

        // Reset in the middle of a drain: everything clears, no done ever
        tick(mk(0, 1, 1, 32'h01020304, Z,            4'b0000, 0, 1), 1);
        tick(mk(0, 0, 0, Z,            32'h01000000, 4'b1000, 0, 0), 1);
        tick(mk(1, 1, 0, 32'h77777777, 32'h00020000, 4'b0100, 0, 0), 1);
        for (int i = 0; i < 6; i++) tick(mk(0, 0, 0, Z, Z, 4'b0000, 0, 1), 1);

        // in_valid held through the drain: D waits for in_ready
        tick(mk(0, 1, 1, 32'h01020304, Z,            4'b0000, 0, 1), 1);
        tick(mk(0, 1, 0, 32'h09090909, 32'h01000000, 4'b1000, 0, 0), 1);
        tick(mk(0, 1, 0, 32'h09090909, 32'h00020000, 4'b0100, 0, 0), 1);
        tick(mk(0, 1, 0, 32'h09090909, 32'h00000300, 4'b0010, 0, 0), 1);
        tick(mk(0, 1, 0, 32'h09090909, 32'h00000004, 4'b0001, 1, 0), 1);
        tick(mk(0, 1, 0, 32'h09090909, Z,            4'b0000, 0, 1), 1);
        tick(mk(0, 0, 0, Z,            32'h09000000, 4'b1000, 0, 1), 1);

        // Randomized traffic, model-checked only
        for (int n = 0; n < 1500; n++) begin
            t = mk(($urandom_range(0, 99) == 0), ($urandom_range(0, 2) != 0),
                   ($urandom_range(0, 7) == 0), $urandom, Z, 4'b0, 0, 0);
            tick(t, 0);
        end
        tick(mk(0, 0, 0, Z, Z, 4'b0, 0, 0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
